// File: rtl/keypad_cmd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : keypad_cmd_ctrl                                               |
// | Purpose  : 4x4 keypad row scanner, key debouncer and motor command       |
// |            assembler (speed 0..15 plus turn direction).                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module keypad_cmd_ctrl #(
   parameter int SCAN_DIV       = 25000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk100,
   input  logic       reset,
   input  logic       enable,
   input  logic [3:0] Columna,
   output logic [3:0] Fila,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic [3:0] speed,
   output logic       turn,
   output logic       isDone
);

   localparam int c_DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int c_CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [c_DW-1:0] c_DWELL_LAST = c_DW'(SCAN_DIV - 1);
   localparam logic [c_CW-1:0] c_DEB_TARGET = c_CW'(DEBOUNCE_SCANS);
   localparam logic [c_CW-1:0] c_CNT_ONE    = c_CW'(1);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_DEB   = 2'd1;
   localparam logic [1:0] c_PRESS = 2'd2;
   localparam logic [1:0] c_REL   = 2'd3;

   localparam logic [3:0] c_KEY_A    = 4'd10;
   localparam logic [3:0] c_KEY_B    = 4'd11;
   localparam logic [3:0] c_KEY_C    = 4'd12;
   localparam logic [3:0] c_KEY_D    = 4'd13;
   localparam logic [3:0] c_KEY_STAR = 4'd14;
   localparam logic [3:0] c_KEY_HASH = 4'd15;

   // Physical position {row,col} to key code.
   function automatic logic [3:0] key_map(input logic [3:0] pos);
      case (pos)
         4'd0:    key_map = 4'd1;
         4'd1:    key_map = 4'd2;
         4'd2:    key_map = 4'd3;
         4'd3:    key_map = c_KEY_A;
         4'd4:    key_map = 4'd4;
         4'd5:    key_map = 4'd5;
         4'd6:    key_map = 4'd6;
         4'd7:    key_map = c_KEY_B;
         4'd8:    key_map = 4'd7;
         4'd9:    key_map = 4'd8;
         4'd10:   key_map = 4'd9;
         4'd11:   key_map = c_KEY_C;
         4'd12:   key_map = c_KEY_STAR;
         4'd13:   key_map = 4'd0;
         4'd14:   key_map = c_KEY_HASH;
         default: key_map = c_KEY_D;
      endcase
   endfunction

   logic [3:0] r_col_meta;
   logic [3:0] r_col_sync;

   always_ff @(posedge clk100) begin
      if (reset) begin
         r_col_meta <= 4'd0;
         r_col_sync <= 4'd0;
      end else begin
         r_col_meta <= Columna;
         r_col_sync <= r_col_meta;
      end
   end

   logic [1:0]      r_row;
   logic [c_DW-1:0] r_dwell;
   logic            w_sample;
   logic            w_scan_done;

   assign w_sample    = (r_dwell == c_DWELL_LAST);
   assign w_scan_done = w_sample && (r_row == 2'd3);
   assign Fila        = 4'b0001 << r_row;

   always_ff @(posedge clk100) begin
      if (reset) begin
         r_row   <= 2'd0;
         r_dwell <= '0;
      end else if (w_sample) begin
         r_row   <= r_row + 2'd1;
         r_dwell <= '0;
      end else begin
         r_dwell <= r_dwell + c_DW'(1);
      end
   end

   // Contact count per scan saturates at 2, meaning "ghosted / multiple".
   logic [1:0] r_acc_cnt;
   logic [3:0] r_acc_pos;
   logic [1:0] w_base_cnt;
   logic [3:0] w_base_pos;
   logic [2:0] w_row_hits;
   logic [1:0] w_col_idx;
   logic [1:0] w_acc_cnt_nxt;
   logic [3:0] w_acc_pos_nxt;
   logic       w_res_valid;
   logic [3:0] w_res_code;

   always_comb begin
      w_base_cnt = (r_row == 2'd0) ? 2'd0 : r_acc_cnt;
      w_base_pos = (r_row == 2'd0) ? 4'd0 : r_acc_pos;
      w_row_hits = 3'd0;
      w_col_idx  = 2'd0;
      for (int c = 0; c < 4; c++) begin
         if (r_col_sync[c]) begin
            w_row_hits = w_row_hits + 3'd1;
            w_col_idx  = 2'(c);
         end
      end
      w_acc_cnt_nxt = w_base_cnt;
      w_acc_pos_nxt = w_base_pos;
      if (w_row_hits != 3'd0) begin
         if ((w_base_cnt == 2'd0) && (w_row_hits == 3'd1)) begin
            w_acc_cnt_nxt = 2'd1;
            w_acc_pos_nxt = {r_row, w_col_idx};
         end else begin
            w_acc_cnt_nxt = 2'd2;
         end
      end
   end

   assign w_res_valid = (w_acc_cnt_nxt == 2'd1);
   assign w_res_code  = key_map(w_acc_pos_nxt);

   always_ff @(posedge clk100) begin
      if (reset) begin
         r_acc_cnt <= 2'd0;
         r_acc_pos <= 4'd0;
      end else if (w_sample) begin
         r_acc_cnt <= w_acc_cnt_nxt;
         r_acc_pos <= w_acc_pos_nxt;
      end
   end

   logic [1:0]      r_state;
   logic [3:0]      r_cand;
   logic [c_CW-1:0] r_deb_cnt;
   logic [c_CW-1:0] r_rel_cnt;
   logic [c_CW-1:0] w_deb_inc;
   logic [c_CW-1:0] w_rel_inc;

   assign w_deb_inc = r_deb_cnt + c_CNT_ONE;
   assign w_rel_inc = r_rel_cnt + c_CNT_ONE;

   always_ff @(posedge clk100) begin
      if (reset) begin
         r_state   <= c_IDLE;
         r_cand    <= 4'd0;
         r_deb_cnt <= '0;
         r_rel_cnt <= '0;
         key_valid <= 1'b0;
         key_code  <= 4'd0;
      end else begin
         key_valid <= 1'b0;
         if (!enable) begin
            r_state   <= c_IDLE;
            r_deb_cnt <= '0;
         end else begin
            case (r_state)
               c_IDLE: begin
                  if (w_scan_done && w_res_valid) begin
                     r_cand    <= w_res_code;
                     r_deb_cnt <= c_CNT_ONE;
                     if (c_CNT_ONE == c_DEB_TARGET) begin
                        r_state   <= c_PRESS;
                        key_valid <= 1'b1;
                        key_code  <= w_res_code;
                     end else begin
                        r_state <= c_DEB;
                     end
                  end
               end
               c_DEB: begin
                  if (w_scan_done) begin
                     if (!w_res_valid) begin
                        r_state <= c_IDLE;
                     end else if (w_res_code == r_cand) begin
                        r_deb_cnt <= w_deb_inc;
                        if (w_deb_inc == c_DEB_TARGET) begin
                           r_state   <= c_PRESS;
                           key_valid <= 1'b1;
                           key_code  <= r_cand;
                        end
                     end else begin
                        r_cand    <= w_res_code;
                        r_deb_cnt <= c_CNT_ONE;
                     end
                  end
               end
               c_PRESS: begin
                  r_state   <= c_REL;
                  r_rel_cnt <= '0;
               end
               default: begin
                  // A still-held key keeps the release count at zero, so no auto-repeat.
                  if (w_scan_done) begin
                     if (w_res_valid) begin
                        r_rel_cnt <= '0;
                     end else if (w_rel_inc == c_DEB_TARGET) begin
                        r_state   <= c_IDLE;
                        r_rel_cnt <= '0;
                     end else begin
                        r_rel_cnt <= w_rel_inc;
                     end
                  end
               end
            endcase
         end
      end
   end

   logic [3:0] r_entry;
   logic       r_pend_turn;
   logic [7:0] w_entry_calc;
   logic [3:0] w_entry_sat;

   assign w_entry_calc = ({4'd0, r_entry} * 8'd10) + {4'd0, key_code};
   assign w_entry_sat  = (w_entry_calc > 8'd15) ? 4'd15 : w_entry_calc[3:0];

   always_ff @(posedge clk100) begin
      if (reset) begin
         r_entry     <= 4'd0;
         r_pend_turn <= 1'b0;
         speed       <= 4'd0;
         turn        <= 1'b0;
         isDone      <= 1'b0;
      end else begin
         isDone <= 1'b0;
         if (key_valid) begin
            case (key_code)
               c_KEY_A:    r_pend_turn <= 1'b0;
               c_KEY_B:    r_pend_turn <= 1'b1;
               c_KEY_C:    ;
               c_KEY_STAR: r_entry <= 4'd0;
               c_KEY_HASH: begin
                  speed  <= r_entry;
                  turn   <= r_pend_turn;
                  isDone <= 1'b1;
               end
               c_KEY_D: begin
                  speed   <= 4'd0;
                  r_entry <= 4'd0;
                  isDone  <= 1'b1;
               end
               default:    r_entry <= w_entry_sat;
            endcase
         end
      end
   end

endmodule
`default_nettype wire
